// File: rtl/mod_n_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_event_pkg
// Description : Shared definitions for the modulo-N event-counting FSM:
//               event qualification mode encodings and the state-width
//               helper used to size the state register.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_n_event_pkg;

    // Event qualification modes
    localparam int MODE_LEVEL = 0;  // event on every cycle the input is high
    localparam int MODE_EDGE  = 1;  // event only on a 0->1 transition

    // Width of a state register able to hold values 0..n-1, never below 1 bit
    // (a 1-state counter would otherwise collapse to a zero-width vector).
    function automatic int calc_state_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Optional multi-flop synchroniser for the raw event input,
//               followed by level or rising-edge event qualification.
// Revision    : 1.0 - initial release
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   a_i      in   raw event input (may be asynchronous when synchronised)
//   ev_o     out  qualified event, combinational from the synchronised input
// ============================================================================
module sync_edge_det
    import mod_n_event_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int EDGE_MODE   = MODE_LEVEL
) (
    input  logic clock,
    input  logic reset_n,
    input  logic a_i,
    output logic ev_o
);

    logic a_s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign a_s = a_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Shift toward the MSB; the MSB is the fully synchronised sample.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= SYNC_STAGES'({sync_q, a_i});
                end
            end

            assign a_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    generate
        if (EDGE_MODE == MODE_EDGE) begin : g_edge
            logic a_prev_q;

            // Tracks the synchronised input every cycle regardless of enable,
            // so an edge seen while the counter is disabled is consumed.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    a_prev_q <= 1'b0;
                end else begin
                    a_prev_q <= a_s;
                end
            end

            assign ev_o = a_s & ~a_prev_q;
        end else begin : g_level
            assign ev_o = a_s;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mod_n_event_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_event_fsm
// Description : Modulo-N event-counting state machine. Advances one state per
//               qualified event on `a` while enabled, wrapping N-1 -> 0, with
//               synchronous clear, a registered wrap pulse and a registered
//               threshold output `y` that lags the state by one clock.
// Revision    : 1.0 - initial release
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   enable   in   state advance enable
//   clear    in   synchronous clear to state 0, overrides enable
//   a        in   event input
//   state_o  out  current state (direct from the state register)
//   y        out  registered (state >= Y_THRESHOLD)
//   wrap     out  one-cycle pulse coinciding with the N-1 -> 0 advance
// ============================================================================
module mod_n_event_fsm
    import mod_n_event_pkg::*;
#(
    parameter int N           = 3,
    parameter int EDGE_MODE   = MODE_LEVEL,
    parameter int SYNC_STAGES = 0,
    parameter int Y_THRESHOLD = 1,
    localparam int SW         = calc_state_width(N)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          clear,
    input  logic          a,
    output logic [SW-1:0] state_o,
    output logic          y,
    output logic          wrap
);

    localparam logic [SW-1:0] STATE_FIRST = '0;
    localparam logic [SW-1:0] STATE_ONE   = SW'(1);
    localparam logic [SW-1:0] STATE_LAST  = SW'(N - 1);
    localparam logic [SW-1:0] Y_LEVEL     = SW'(Y_THRESHOLD);

    logic          ev;
    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          y_q;
    logic          y_d;
    logic          wrap_q;
    logic          wrap_d;
    logic          at_last;
    logic          illegal;
    logic          y_hit;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge_det (
        .clock   (clock),
        .reset_n (reset_n),
        .a_i     (a),
        .ev_o    (ev)
    );

    assign at_last = (state_q == STATE_LAST);

    // Encodings above N-1 exist only when N is not a power of two; the
    // comparison is generated only then so it is never a constant compare.
    generate
        if (N < (1 << SW)) begin : g_sparse
            assign illegal = (state_q > STATE_LAST);
        end else begin : g_dense
            assign illegal = 1'b0;
        end
    endgenerate

    generate
        if (Y_THRESHOLD == 0) begin : g_y_always
            assign y_hit = 1'b1;
        end else begin : g_y_cmp
            assign y_hit = (state_q >= Y_LEVEL);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_FIRST;
            y_q     <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (illegal) begin
            // Recover from an unreachable encoding even while disabled.
            state_d = STATE_FIRST;
        end else if (clear) begin
            state_d = STATE_FIRST;
        end else if (enable && ev) begin
            state_d = at_last ? STATE_FIRST : (state_q + STATE_ONE);
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered in the state register process)
    // ------------------------------------------------------------------
    always_comb begin
        wrap_d = ~clear & enable & ev & at_last;
        // Derived from the current state, so y trails state_o by a clock.
        y_d    = y_hit;
    end

    assign state_o = state_q;
    assign y       = y_q;
    assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_event_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_n_event_fsm
// Description : Self-checking bench for mod_n_event_fsm. Six parameter
//               variants share one stimulus; a behavioural model is compared
//               against every instance each cycle, and directed literal
//               expectations pin the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_n_event_fsm;

    localparam int NI = 6;
    // Per-instance parameters, in instance order u0..u5
    localparam int P_N [NI] = '{3, 5, 4, 4, 6, 2};
    localparam int P_E [NI] = '{0, 1, 0, 0, 0, 1};
    localparam int P_S [NI] = '{0, 0, 2, 0, 0, 3};
    localparam int P_Y [NI] = '{1, 1, 1, 1, 4, 0};

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic enable  = 1'b0;
    logic clear   = 1'b0;
    logic a       = 1'b0;

    logic [1:0] st0, st2, st3;
    logic [2:0] st1, st4;
    logic [0:0] st5;
    logic [NI-1:0] yv, wv;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    mod_n_event_fsm #(.N(3), .EDGE_MODE(0), .SYNC_STAGES(0), .Y_THRESHOLD(1)) u0 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
        .state_o(st0), .y(yv[0]), .wrap(wv[0]));
    mod_n_event_fsm #(.N(5), .EDGE_MODE(1), .SYNC_STAGES(0), .Y_THRESHOLD(1)) u1 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
        .state_o(st1), .y(yv[1]), .wrap(wv[1]));
    mod_n_event_fsm #(.N(4), .EDGE_MODE(0), .SYNC_STAGES(2), .Y_THRESHOLD(1)) u2 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
        .state_o(st2), .y(yv[2]), .wrap(wv[2]));
    mod_n_event_fsm #(.N(4), .EDGE_MODE(0), .SYNC_STAGES(0), .Y_THRESHOLD(1)) u3 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
        .state_o(st3), .y(yv[3]), .wrap(wv[3]));
    mod_n_event_fsm #(.N(6), .EDGE_MODE(0), .SYNC_STAGES(0), .Y_THRESHOLD(4)) u4 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
        .state_o(st4), .y(yv[4]), .wrap(wv[4]));
    mod_n_event_fsm #(.N(2), .EDGE_MODE(1), .SYNC_STAGES(3), .Y_THRESHOLD(0)) u5 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .a(a),
        .state_o(st5), .y(yv[5]), .wrap(wv[5]));

    // ------------------------------------------------------------------
    // Behavioural model: count of qualified events modulo N, a delayed by
    // SYNC_STAGES samples, y/wrap derived from the count before each edge.
    // ------------------------------------------------------------------
    int m_state [NI];
    bit m_y     [NI];
    bit m_wrap  [NI];
    bit m_prev  [NI];
    bit m_hist  [NI][3];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_state[i] = 0;
            m_y[i]     = 1'b0;
            m_wrap[i]  = 1'b0;
            m_prev[i]  = 1'b0;
            for (int k = 0; k < 3; k++) m_hist[i][k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            bit as;
            bit ev;
            as = (P_S[i] == 0) ? a : m_hist[i][P_S[i]-1];
            for (int k = 2; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = a;
            ev = (P_E[i] == 1) ? (as && !m_prev[i]) : as;
            m_prev[i] = as;
            m_y[i]    = (m_state[i] >= P_Y[i]);
            m_wrap[i] = !clear && enable && ev && (m_state[i] == P_N[i] - 1);
            if (clear)              m_state[i] = 0;
            else if (enable && ev)  m_state[i] = (m_state[i] + 1) % P_N[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int dut_state(input int i);
        case (i)
            0: return int'(st0);
            1: return int'(st1);
            2: return int'(st2);
            3: return int'(st3);
            4: return int'(st4);
            default: return int'(st5);
        endcase
    endfunction

    // Per-cycle comparison of every instance against the model
    initial begin
        forever begin
            @(negedge clock);
            for (int i = 0; i < NI; i++) begin
                check($sformatf("model u%0d.state", i), dut_state(i), m_state[i]);
                check($sformatf("model u%0d.y", i),     int'(yv[i]),  int'(m_y[i]));
                check($sformatf("model u%0d.wrap", i),  int'(wv[i]),  int'(m_wrap[i]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        a       = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int exp_s [7] = '{1, 2, 0, 1, 2, 0, 1};
        int exp_w [7] = '{0, 0, 1, 0, 0, 1, 0};
        int exp_y [7] = '{0, 1, 1, 0, 1, 1, 0};
        int e4_s  [6] = '{1, 2, 3, 4, 5, 0};
        int e4_y  [6] = '{0, 0, 0, 0, 1, 1};
        int e4_w  [6] = '{0, 0, 0, 0, 0, 1};

        #1 reset_n = 1'b0;
        tick();
        tick();
        check("reset state", int'(st0), 0);
        check("reset y",     int'(yv[0]), 0);
        check("reset wrap",  int'(wv[0]), 0);

        // Defaults, level mode: a = 1 for 7 cycles
        reset_n = 1'b1;
        enable  = 1'b1;
        a       = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("p1 state[%0d]", k), int'(st0),   exp_s[k]);
            check($sformatf("p1 wrap[%0d]", k),  int'(wv[0]), exp_w[k]);
            check($sformatf("p1 y[%0d]", k),     int'(yv[0]), exp_y[k]);
            if (k == 0) check("y threshold 0 first clock", int'(yv[5]), 1);
        end

        // Edge mode, N = 5: one event per high pulse
        do_reset();
        enable = 1'b1;
        for (int p = 0; p < 5; p++) begin
            a = 1'b1;
            tick();
            if (p == 4) begin
                check("edge wrap state", int'(st1),   0);
                check("edge wrap pulse", int'(wv[1]), 1);
            end
            tick();
            if (p == 4) check("edge wrap one cycle", int'(wv[1]), 0);
            repeat (8) tick();
            a = 1'b0;
            repeat (3) tick();
            if (p == 2) begin
                check("edge 3 pulses state", int'(st1),   3);
                check("edge 3 pulses wrap",  int'(wv[1]), 0);
            end
        end

        // Clear overrides an advance that would have wrapped
        do_reset();
        enable = 1'b1;
        a      = 1'b1;
        tick();
        tick();
        check("clear pre state", int'(st0), 2);
        clear = 1'b1;
        tick();
        check("clear state", int'(st0),   0);
        check("clear wrap",  int'(wv[0]), 0);
        clear  = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        check("disabled hold", int'(st0), 0);

        // Synchroniser latency: single-cycle pulse, SYNC 2 vs SYNC 0
        do_reset();
        enable = 1'b1;
        a      = 1'b1;
        tick();
        check("sync0 step",     int'(st3), 1);
        check("sync2 no step0", int'(st2), 0);
        a = 1'b0;
        tick();
        check("sync2 no step1", int'(st2),   0);
        check("sync0 y",        int'(yv[3]), 1);
        tick();
        check("sync2 step",     int'(st2),   1);
        check("sync2 y low",    int'(yv[2]), 0);
        tick();
        check("sync2 y high",   int'(yv[2]), 1);

        // N = 6, Y_THRESHOLD = 4
        do_reset();
        enable = 1'b1;
        a      = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("thr state[%0d]", k), int'(st4),   e4_s[k]);
            check($sformatf("thr y[%0d]", k),     int'(yv[4]), e4_y[k]);
            check($sformatf("thr wrap[%0d]", k),  int'(wv[4]), e4_w[k]);
        end
        a = 1'b0;
        tick();
        check("thr y after wrap", int'(yv[4]), 0);

        // Asynchronous reset mid-count
        do_reset();
        enable = 1'b1;
        a      = 1'b1;
        repeat (3) tick();
        check("mid pre state", int'(st4),   3);
        check("mid pre y0",    int'(yv[0]), 1);
        check("mid pre wrap0", int'(wv[0]), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async state",  int'(st4),   0);
        check("async y0",     int'(yv[0]), 0);
        check("async wrap0",  int'(wv[0]), 0);
        check("async state0", int'(st0),   0);
        tick();
        reset_n = 1'b1;
        enable  = 1'b0;
        a       = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
